block_ram_multi_word_init: RTL and testbench

BLOCK_RAM_MULTI_WORD_INIT -- requirements
Module: block_ram_multi_word_init

---
 rtl/block_ram_pkg.sv | 15 +
 rtl/ram_init_sweeper.sv | 56 +++++
 rtl/block_ram_multi_word_init.sv | 116 +++++++++++
 tb/tb_block_ram_multi_word_init.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_ram_pkg.sv
// Shared definitions for the multi-word block RAM: sweep FSM encoding and
// the legal string values of the read-policy and output-stage parameters.
package block_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sweep_state_e;

  localparam string RDW_READ_FIRST  = "read_first";
  localparam string RDW_WRITE_FIRST = "write_first";
  localparam string OUT_REG_TRUE    = "true";
  localparam string OUT_REG_FALSE   = "false";

endpackage

// File: rtl/ram_init_sweeper.sv
// Fill-sweep controller: walks every entry once after reset or on request,
// producing the sweep address and write strobe for the RAM array.
module ram_init_sweeper
  import block_ram_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_start,
  output logic                     init_busy,
  output logic [$clog2(DEPTH)-1:0] sweep_addr,
  output logic                     sweep_we
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  sweep_state_e  state;
  logic [AW-1:0] addr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      addr  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (addr == LAST_ADDR) begin
            state <= ST_READY;
            addr  <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        ST_READY: begin
          if (init_start) begin
            state <= ST_INIT;
            addr  <= '0;
          end
        end
        default: begin
          state <= ST_INIT;
          addr  <= '0;
        end
      endcase
    end
  end

  assign init_busy  = (state == ST_INIT);
  assign sweep_we   = (state == ST_INIT);
  assign sweep_addr = addr;

endmodule

// File: rtl/block_ram_multi_word_init.sv
// Multi-lane block RAM with per-lane write enables, selectable read-during-write
// policy, optional output register, and a fill sweep after reset or on request.
module block_ram_multi_word_init
  import block_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    DEPTH           = 64,
  parameter int                    NUM_WORDS       = 4,
  parameter string                 RAM_STYLE       = "auto",
  parameter string                 OUTPUT_REGISTER = "false",
  parameter string                 RDW_MODE        = "read_first",
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE      = '1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              init_start,
  output logic                              init_busy,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0]          wr_addr,
  input  logic [NUM_WORDS-1:0]              wr_en,
  input  logic [$clog2(DEPTH)-1:0]          rd_addr,
  input  logic                              rd_en,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]   rd_data,
  output logic                              rd_valid
);

  localparam int  AW          = $clog2(DEPTH);
  localparam int  W           = DATA_WIDTH * NUM_WORDS;
  localparam bit  WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);
  localparam bit  RDW_OK      = (RDW_MODE == RDW_READ_FIRST) || WRITE_FIRST;
  localparam bit  OUT_REG     = (OUTPUT_REGISTER == OUT_REG_TRUE);
  localparam bit  OUT_OK      = (OUTPUT_REGISTER == OUT_REG_FALSE) || OUT_REG;
  localparam bit  STYLE_OK    = (RAM_STYLE != "");

  if (!(RDW_OK && OUT_OK && STYLE_OK && DEPTH >= 2)) begin : g_bad_param
    $error("block_ram_multi_word_init: illegal RDW_MODE, OUTPUT_REGISTER, RAM_STYLE or DEPTH");
  end

  logic [AW-1:0] sweep_addr;
  logic          sweep_we;

  ram_init_sweeper #(
    .DEPTH (DEPTH)
  ) u_sweeper (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (init_start),
    .init_busy  (init_busy),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we)
  );

  (* ram_style = RAM_STYLE *) logic [W-1:0] mem [DEPTH];

  // NOTE: storage has no reset so it can map onto block RAM; the sweep
  // establishes its contents instead.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= {NUM_WORDS{INIT_VALUE}};
    end else begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (wr_en[k]) mem[wr_addr][k*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
      end
    end
  end

  logic [W-1:0] rd_word;
  logic         rd_fire;

  assign rd_fire = rd_en && !init_busy;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd_word = mem[rd_addr];
    if (WRITE_FIRST && (wr_addr == rd_addr)) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (wr_en[k]) rd_word[k*DATA_WIDTH +: DATA_WIDTH] = wr_data;
      end
    end
  end

  logic [W-1:0] s1_data;
  logic         s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) s1_data <= rd_word;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [W-1:0] s2_data;
    logic         s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign rd_data  = s2_data;
    assign rd_valid = s2_valid;
  end else begin : g_no_out_reg
    assign rd_data  = s1_data;
    assign rd_valid = s1_valid;
  end

endmodule

// File: tb/tb_block_ram_multi_word_init.sv
// Randomized self-checking bench for block_ram_multi_word_init against a
// lane-array model with a latency queue of pending read results.
module tb_block_ram_multi_word_init;

  localparam int    DW      = 8;
  localparam int    DEPTH   = 64;
  localparam int    NW      = 4;
  localparam int    AW      = $clog2(DEPTH);
  localparam int    W       = DW * NW;
  localparam string OUT_REG = "false";
  localparam string RDW     = "read_first";
  localparam int    LAT     = (OUT_REG == "true") ? 2 : 1;
  localparam bit    WF      = (RDW == "write_first");
  localparam logic [DW-1:0] INIT = 8'hFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          init_start = 1'b0;
  logic          init_busy;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [NW-1:0] wr_en = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_en = 1'b0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;

  block_ram_multi_word_init #(
    .DATA_WIDTH      (DW),
    .DEPTH           (DEPTH),
    .NUM_WORDS       (NW),
    .RAM_STYLE       ("block"),
    .OUTPUT_REGISTER (OUT_REG),
    .RDW_MODE        (RDW),
    .INIT_VALUE      (INIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (init_start),
    .init_busy  (init_busy),
    .wr_data    (wr_data),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  // Reference model: lane array, remaining sweep cycles, queue of read results.
  typedef struct {
    int           due;
    logic [W-1:0] data;
  } pend_t;

  logic [DW-1:0] model [DEPTH][NW];
  pend_t         pq[$];
  int            m_remaining;
  int            cyc;
  logic          exp_valid;
  logic [W-1:0]  exp_data;
  int            n_total;
  int            n_pass;

  task automatic model_fill();
    for (int a = 0; a < DEPTH; a++)
      for (int k = 0; k < NW; k++) model[a][k] = INIT;
  endtask

  task automatic model_reset();
    model_fill();
    m_remaining = DEPTH;
    pq.delete();
    exp_valid = 1'b0;
    exp_data  = '0;
  endtask

  task automatic idle();
    init_start = 1'b0;
    rd_en      = 1'b0;
    wr_en      = '0;
  endtask

  // Applies the current inputs to the model, then advances the DUT one edge.
  task automatic step();
    logic [W-1:0] word;
    if (m_remaining > 0) begin
      m_remaining--;
    end else begin
      if (rd_en) begin
        for (int k = 0; k < NW; k++)
          word[k*DW +: DW] = (WF && wr_en[k] && wr_addr == rd_addr) ? wr_data : model[rd_addr][k];
        pq.push_back('{cyc + LAT, word});
      end
      for (int k = 0; k < NW; k++)
        if (wr_en[k]) model[wr_addr][k] = wr_data;
      if (init_start) begin
        model_fill();
        m_remaining = DEPTH;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_valid = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      exp_valid = 1'b1;
      exp_data  = pq[0].data;
      void'(pq.pop_front());
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || init_busy !== 1'b1)
      $display("FAIL reset_state: data=%h valid=%b busy=%b, want data=0 valid=0 busy=1",
               rd_data, rd_valid, init_busy);
    else n_pass++;
    release_reset();
    n = 0;
    do begin
      step();
      n++;
    end while (init_busy && n < 200);
    n_total++;
    if (n !== DEPTH) $display("FAIL reset_sweep_len: busy cycles=%0d, want %0d", n, DEPTH);
    else n_pass++;
  endtask

  task automatic test_init_fill();
    for (int a = 0; a < DEPTH + LAT; a++) begin
      rd_en   = (a < DEPTH);
      rd_addr = AW'(a);
      step();
      n_total++;
      if (rd_valid !== exp_valid || rd_data !== exp_data ||
          (exp_valid && rd_data !== {NW{INIT}}))
        $display("FAIL init_fill step%0d: valid=%b data=%h, want valid=%b data=%h",
                 a, rd_valid, rd_data, exp_valid, exp_data);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_lane_write();
    wr_addr = 5; wr_data = 8'hA5; wr_en = 4'b0101;
    step();
    idle();
    rd_en = 1'b1; rd_addr = 5;
    step();
    rd_en = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      if (i > 1) step();
      n_total++;
      if (rd_valid !== (i == LAT) || (i == LAT && rd_data !== 32'hFFA5FFA5) ||
          rd_data !== exp_data)
        $display("FAIL lane_write lat%0d: valid=%b data=%h, want valid=%b data=%h",
                 i, rd_valid, rd_data, (i == LAT), 32'hFFA5FFA5);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_rdw();
    logic [W-1:0] want;
    want = WF ? 32'hFFFF3CFF : 32'hFFFFFFFF;
    wr_addr = 9; wr_data = 8'h3C; wr_en = 4'b0010;
    rd_addr = 9; rd_en = 1'b1;
    step();
    idle();
    repeat (LAT - 1) step();
    n_total++;
    if (rd_valid !== 1'b1 || rd_data !== want || rd_data !== exp_data)
      $display("FAIL rdw_same_cycle: valid=%b data=%h, want valid=1 data=%h", rd_valid, rd_data, want);
    else n_pass++;
    rd_en = 1'b1;
    step();
    idle();
    repeat (LAT - 1) step();
    n_total++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hFFFF3CFF)
      $display("FAIL rdw_readback: valid=%b data=%h, want valid=1 data=%h", rd_valid, rd_data, 32'hFFFF3CFF);
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rd_en   = $urandom_range(0, 1);
      rd_addr = AW'($urandom_range(0, 7));
      wr_addr = AW'($urandom_range(0, 7));
      wr_en   = ($urandom_range(0, 2) == 0) ? '0 : NW'($urandom);
      wr_data = DW'($urandom);
      if (i % 50 == 0) begin
        rd_addr = AW'($urandom_range(0, DEPTH - 1));
        wr_addr = rd_addr;
      end
      step();
      n_total++;
      if (rd_valid !== exp_valid || rd_data !== exp_data || init_busy !== (m_remaining > 0))
        $display("FAIL random cyc%0d: valid=%b data=%h busy=%b, want valid=%b data=%h busy=%b",
                 i, rd_valid, rd_data, init_busy, exp_valid, exp_data, (m_remaining > 0));
      else n_pass++;
    end
    idle();
    repeat (LAT) step();
  endtask

  task automatic test_init_during();
    for (int a = 0; a < 4; a++) begin
      wr_addr = AW'(a * 13); wr_data = 8'h5A; wr_en = 4'b1111;
      step();
    end
    idle();
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_en      = 1'b1;
      rd_addr    = AW'($urandom_range(0, DEPTH - 1));
      wr_addr    = rd_addr;
      wr_en      = 4'b1111;
      wr_data    = DW'($urandom);
      init_start = (i == 20);
      step();
      n_total++;
      if (rd_valid !== 1'b0 || rd_data !== exp_data || init_busy !== (i < DEPTH - 1))
        $display("FAIL init_during cyc%0d: valid=%b data=%h busy=%b, want valid=0 data=%h busy=%b",
                 i, rd_valid, rd_data, init_busy, exp_data, (i < DEPTH - 1));
      else n_pass++;
    end
    idle();
    for (int a = 0; a < DEPTH + LAT; a++) begin
      rd_en   = (a < DEPTH);
      rd_addr = AW'(a);
      step();
      if (exp_valid) begin
        n_total++;
        if (rd_valid !== 1'b1 || rd_data !== {NW{INIT}})
          $display("FAIL refill addr%0d: valid=%b data=%h, want valid=1 data=%h",
                   a - LAT + 1, rd_valid, rd_data, {NW{INIT}});
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] want;
    for (int a = 0; a < 8; a++) begin
      wr_addr = AW'(a); wr_data = DW'(a * 17 + 1); wr_en = 4'b1111;
      step();
    end
    idle();
    for (int s = 0; s < 8 + LAT - 1; s++) begin
      rd_en   = (s < 8);
      rd_addr = AW'(s);
      step();
      want = {NW{DW'((s - LAT + 1) * 17 + 1)}};
      n_total++;
      if (s >= LAT - 1) begin
        if (rd_valid !== 1'b1 || rd_data !== want || rd_data !== exp_data)
          $display("FAIL back_to_back slot%0d: valid=%b data=%h, want valid=1 data=%h",
                   s, rd_valid, rd_data, want);
        else n_pass++;
      end else begin
        if (rd_valid !== 1'b0)
          $display("FAIL back_to_back slot%0d: valid=%b, want 0", s, rd_valid);
        else n_pass++;
      end
    end
    idle();
    step();
    n_total++;
    if (rd_valid !== 1'b0 || rd_data !== {NW{8'd120}})
      $display("FAIL back_to_back hold: valid=%b data=%h, want valid=0 data=%h",
               rd_valid, rd_data, {NW{8'd120}});
    else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    idle();
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    repeat (30) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || init_busy !== 1'b1)
      $display("FAIL mid_sweep_reset: data=%h valid=%b busy=%b, want data=0 valid=0 busy=1",
               rd_data, rd_valid, init_busy);
    else n_pass++;
    release_reset();
    n = 0;
    do begin
      step();
      n++;
    end while (init_busy && n < 200);
    n_total++;
    if (n !== DEPTH) $display("FAIL mid_sweep_restart_len: busy cycles=%0d, want %0d", n, DEPTH);
    else n_pass++;
    rd_en = 1'b1; rd_addr = 3;
    step();
    idle();
    repeat (LAT - 1) step();
    n_total++;
    if (rd_valid !== 1'b1 || rd_data !== {NW{INIT}})
      $display("FAIL mid_sweep_after: valid=%b data=%h, want valid=1 data=%h",
               rd_valid, rd_data, {NW{INIT}});
    else n_pass++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    cyc     = 0;
    model_reset();
    test_reset();
    test_init_fill();
    test_lane_write();
    test_rdw();
    test_random();
    test_init_during();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
